// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester IDs and memory geometry for mem_dat_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
    localparam logic REQ_CPU   = 1'b0;
    localparam logic REQ_DBG   = 1'b1;
    localparam int   MEM_DEPTH = 256;
    localparam int   MEM_IDX_W = $clog2(MEM_DEPTH);
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker; prio names the winner only when both request
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_id
);
    assign gnt_valid = |req;
    assign gnt_id    = (&req) ? prio : req[REQ_DBG];
endmodule

// File: rtl/mem_dat_arbiter.sv
// mem_dat_arbiter: round-robin CPU/debug sequencer for the data memory port; MEM_DAT_ARB_RANGE_CHK_EN adds range errors
module mem_dat_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 2 ** MEM_IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_esc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
    output logic              cpu_err,
    output logic              dbg_err,
`endif
    output logic              busy
);
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
    logic err_q;
`else
    localparam bit CHK = 1'b0;
`endif
    state_t            state_q;
    logic              prio_q, owner_q, we_q, ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              gnt_valid, gnt_id, bad;

    rr_pick2 u_pick (
        .req      ({dbg_req, cpu_req}),
        .prio     (prio_q),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id)
    );

    // Without the range check, bad is constant 0 and addresses alias modulo DEPTH
    assign bad = CHK && (addr_q >= ADDR_W'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= REQ_CPU;
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (gnt_valid) begin
                    owner_q <= gnt_id;
                    we_q    <= gnt_id ? dbg_we    : cpu_we;
                    addr_q  <= gnt_id ? dbg_addr  : cpu_addr;
                    wdata_q <= gnt_id ? dbg_wdata : cpu_wdata;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    rdata_q <= bad ? '0 : mem_rdata;
                    ack_q   <= 1'b1;
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
                    err_q   <= bad;
`endif
                    state_q <= RESP;
                end
                RESP: begin
                    ack_q   <= 1'b0;
                    prio_q  <= ~owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_esc   = (state_q == ACCESS) && we_q && !reset && !bad;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = ack_q && (owner_q == REQ_CPU);
    assign dbg_ack   = ack_q && (owner_q == REQ_DBG);
    assign cpu_rdata = rdata_q;
    assign dbg_rdata = rdata_q;
    assign busy      = (state_q != IDLE);
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
    assign cpu_err   = cpu_ack && err_q;
    assign dbg_err   = dbg_ack && err_q;
`endif
endmodule

// File: tb/tb_mem_dat_arbiter.sv
// tb_mem_dat_arbiter: directed vector bench for mem_dat_arbiter with a behavioural 256x64 memory
module tb_mem_dat_arbiter;
    import mem_arb_pkg::*;
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
    logic cpu_err, dbg_err;
`else
    localparam bit CHK = 1'b0;
`endif
    logic        clock = 1'b0, reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
    logic [63:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic        cpu_ack, dbg_ack, mem_esc, busy;
    logic [63:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [63:0] mem [MEM_DEPTH];
    int          total = 0, bad = 0, both_hi = 0;

    typedef struct {
        logic        id;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rd;
        logic        chk_rd;
        logic        esc;
        logic        err;
    } vec_t;
    vec_t v [14];

    mem_dat_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_esc(mem_esc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
        .cpu_err(cpu_err), .dbg_err(dbg_err),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (mem_esc) mem[mem_addr[MEM_IDX_W-1:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[MEM_IDX_W-1:0]];
    always @(negedge clock) if (cpu_ack && dbg_ack) both_hi++;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic id, we, input logic [63:0] a, wd, rd,
                                input logic c, e, er);
        vec_t t;
        t.id = id; t.we = we; t.addr = a; t.wdata = wd; t.rd = rd;
        t.chk_rd = c; t.esc = e; t.err = er;
        return t;
    endfunction

    task automatic drive(input logic id, req, we, input logic [63:0] a, wd);
        if (id) begin
            dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
    endtask

    task automatic run(input vec_t t);
        int n = 0, esc = 0, other = 0;
        logic own;
        drive(t.id, 1'b1, t.we, t.addr, t.wdata);
        do begin
            @(negedge clock);
            n++;
            esc += int'(mem_esc);
            other += int'(t.id ? cpu_ack : dbg_ack);
            own = t.id ? dbg_ack : cpu_ack;
        end while (!own && n < 10);
        chk("latency", 64'(n), 64'd2);
        chk("esc_count", 64'(esc), 64'(t.esc));
        chk("other_ack", 64'(other), 64'd0);
        if (t.chk_rd) chk("rdata", t.id ? dbg_rdata : cpu_rdata, t.rd);
`ifdef MEM_DAT_ARB_RANGE_CHK_EN
        chk("err", 64'(t.id ? dbg_err : cpu_err), 64'(t.err));
`endif
        drive(t.id, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clock);
    endtask

    initial begin
        logic exp_c, exp_d;
        v[0] = mk(REQ_DBG, 1, 44, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            v[1+i] = mk(REQ_DBG, 1, 64'(i), 64'(10*(i+1)), 0, 0, 1, 0);
            v[8+i] = mk(REQ_DBG, 0, 64'(i), 0, 64'(10*(i+1)), 1, 0, 0);
        end
        v[5]  = mk(REQ_DBG, 1, 7, 64'h77, 0, 0, 1, 0);
        v[6]  = mk(REQ_CPU, 1, 5, 64'hDEAD_BEEF, 0, 0, 1, 0);
        v[7]  = mk(REQ_CPU, 0, 5, 0, 64'hDEAD_BEEF, 1, 0, 0);
        v[12] = mk(REQ_CPU, 1, 300, 64'h1234, 0, 1, !CHK, CHK);
        v[13] = mk(REQ_CPU, 0, 44, 0, CHK ? 64'd0 : 64'h1234, 1, 0, 0);

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_acks", 64'({cpu_ack, dbg_ack}), 0);
        chk("rst_esc", 64'(mem_esc), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 0;
        @(negedge clock);

        for (int i = 0; i < 14; i++) run(v[i]);

        // Round robin after reset: CPU first, then alternate every 3 cycles
        reset = 1;
        @(negedge clock);
        reset = 0;
        drive(REQ_CPU, 1, 0, 1, 0);
        drive(REQ_DBG, 1, 0, 2, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            exp_c = (k == 2 || k == 8);
            exp_d = (k == 5 || k == 11);
            chk($sformatf("rr_acks_%0d", k), 64'({cpu_ack, dbg_ack}), 64'({exp_c, exp_d}));
            if (exp_c) chk("rr_cpu_rdata", cpu_rdata, 64'd20);
            if (exp_d) chk("rr_dbg_rdata", dbg_rdata, 64'd30);
        end
        drive(REQ_CPU, 0, 0, 0, 0);
        drive(REQ_DBG, 0, 0, 0, 0);
        @(negedge clock);

        // Reset asserted during a store's ACCESS cycle
        drive(REQ_CPU, 1, 1, 7, 64'h99);
        @(negedge clock);
        chk("c_busy", 64'(busy), 1);
        chk("c_esc_pre", 64'(mem_esc), 1);
        reset = 1;
        drive(REQ_CPU, 0, 0, 0, 0);
        #1 chk("c_esc_rst", 64'(mem_esc), 0);
        @(negedge clock);
        chk("c_busy0", 64'(busy), 0);
        chk("c_acks", 64'({cpu_ack, dbg_ack}), 0);
        chk("c_esc", 64'(mem_esc), 0);
        chk("c_addr", mem_addr, 0);
        chk("c_wdata", mem_wdata, 0);
        reset = 0;
        @(negedge clock);
        chk("c_acks_idle", 64'({cpu_ack, dbg_ack}), 0);
        run(mk(REQ_CPU, 0, 7, 0, 64'h77, 1, 0, 0));

        // Fields changed and req dropped after grant: registered copy still completes
        drive(REQ_CPU, 1, 0, 3, 0);
        @(negedge clock);
        chk("d_mem_addr", mem_addr, 3);
        chk("d_esc", 64'(mem_esc), 0);
        drive(REQ_CPU, 0, 1, 9, 64'hBAD);
        @(negedge clock);
        chk("d_ack", 64'(cpu_ack), 1);
        chk("d_rdata", cpu_rdata, 64'd40);
        @(negedge clock);
        chk("d_idle", 64'({busy, cpu_ack, dbg_ack, mem_esc}), 0);
        chk("both_acks", 64'(both_hi), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_dat_arbiter.md
Name: mem_dat_arbiter

Overview:
- Two-requester arbiter and sequencer for the 64-bit data memory (256 words, combinational read, write on clock edge).
- Shares the single memory port between the CPU load/store stage (port `cpu_*`) and the debug/loader port (port `dbg_*`).
- Round-robin priority; each access is fixed at 3 cycles (IDLE, ACCESS, RESP).
- Guarantees exactly one memory write strobe per granted store and never writes on idle cycles.

Parameters:
- DATA_W, 64, data word width.
- ADDR_W, 64, address width carried on request ports.
- DEPTH, 256, number of memory words; the memory index uses the low log2(DEPTH) address bits.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high with stable fields until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  load data; valid while cpu_ack=1.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* ports, for the debug/loader port.
- mem_esc  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (sync, when reset=1 at posedge):
  - state=IDLE, prio=CPU.
  - owner_q, we_q, addr_q, wdata_q, rdata_q all zero.
  - All acks 0; mem_esc 0; mem_addr 0; mem_wdata 0; busy 0.
- mem_esc is combinationally gated by !reset, so no write can occur in a reset cycle even if the state is ACCESS.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both reqs: grant the requester named by prio.
  - On grant, register owner/we/addr/wdata, then go to ACCESS.
- ACCESS (1 cycle):
  - mem_addr=addr_q, mem_wdata=wdata_q, mem_esc=we_q.
  - rdata_q <= mem_rdata at the end of the cycle.
  - Next state RESP.
- RESP (1 cycle):
  - Owner's ack=1; owner's rdata=rdata_q (loads only; stores return the value read before the write).
  - prio <= the non-owner requester.
  - Next state IDLE.
- Latency: req sampled at edge N → ack high in cycle N+2; throughput is 1 access per 3 cycles.
- The requester must drop or reassert req in the cycle after ack. A req still high in the IDLE cycle after RESP is treated as a new request.
- Outside ACCESS: mem_addr/mem_wdata hold their last values; mem_esc=0.
- Non-owner ack stays 0. Both acks are never high together.
- Request fields changing after grant are ignored (the registered copy is used).
- The request is dropped during ACCESS or RESP: the access still completes and ack still pulses.
- Reset mid-operation:
  - Any in-flight access is discarded and no ack is issued.
  - A store in ACCESS during a reset cycle is not written.
- Memory index is addr_q[log2(DEPTH)-1:0]; upper address bits are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_DAT_ARB_RANGE_CHK_EN.
- Defined:
  - Adds outputs cpu_err and dbg_err (1 bit each, valid with ack, reset 0).
  - In ACCESS, if addr_q >= DEPTH: mem_esc is forced to 0, rdata_q <= 0, and RESP pulses ack with err=1.
  - Timing is unchanged.
- Undefined:
  - No err ports.
  - Out-of-range addresses alias modulo DEPTH.

Decomposition:
- Package mem_arb_pkg:
  - State encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Requester IDs REQ_CPU=1'b0, REQ_DBG=1'b1.
  - Localparam for the index width derived from DEPTH.
- One sub-module, rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], prio.
  - Outputs: gnt_valid, gnt_id.
- All registers and the FSM stay in mem_dat_arbiter.

Test Plan:
- CPU store addr=5, wdata=64'hDEAD_BEEF, then CPU load addr=5 → mem_esc high exactly 1 cycle; load ack at N+2 with cpu_rdata=64'hDEAD_BEEF.
- cpu_req and dbg_req both high continuously, distinct addrs 1/2 → grants alternate CPU, DBG, CPU, DBG (prio starts CPU); acks every 3 cycles; never both acks high.
- Only dbg_req, loads addr 0..3 preloaded 10,20,30,40 → dbg_ack pulses with 10,20,30,40; cpu_ack stays 0.
- Store addr=7 with reset asserted during the ACCESS cycle → mem_esc=0 in that cycle; a subsequent load of addr=7 returns the old value; no ack pulse; all outputs 0 the cycle after reset.
- Change cpu_addr 3→9 in the cycle after grant → the access uses addr 3; ack still at N+2.
- MEM_DAT_ARB_RANGE_CHK_EN defined, store addr=300 → mem_esc never high; cpu_ack with cpu_err=1, cpu_rdata=0. Undefined: write lands at index 44.
